bus_uart_tx: RTL and testbench
==============================

// Module: bus_uart_tx
// PURPOSE
//   CPU-bus responder that accepts bytes from the CPU via the start/busy memory handshake, buffers them in a FIFO and serialises them as 8N1 UART frames.
//   Sits beside MemoryUnit's other I/O slaves: the address decoder drives sel, q is muxed back to the CPU, and irq feeds one of the CPU int lines.
// PARAMETERS
//   FIFO_DEPTH   16    TX FIFO entries (power of 2, 2..256)
//   DIV_DEFAULT  217   clk cycles per UART bit after reset (25 MHz / 115200)
// PORTS
//   clk      in   1   system clock (25 MHz domain, same as CPU)
//   reset    in   1   synchronous, active-high reset
//   sel      in   1   address decoder hit for this block
//   address  in   2   word register index
//   data     in   32  write data from CPU
//   we       in   1   1 = write access, 0 = read access
//   start    in   1   access request; sampled only when sel=1 and busy=0
//   busy     out  1   access in progress
//   q        out  32  read data
//   uart_tx  out  1   serial output, idle high
//   irq      out  1   1-cycle pulse: FIFO drained and line idle
// BEHAVIOUR
//   Reset: busy=0, q=0, uart_tx=1, irq=0, FIFO empty, divisor=DIV_DEFAULT, ctrl=0, overflow=0, FSM=IDLE.
//   Handshake: busy = (start & sel & ~busy_r) | busy_r. busy_r is set on the accepted start cycle N and cleared at N+1.
//     Register write takes effect at edge N. q is registered at edge N and held until the next accepted read.
//     Access is complete at N+1 (busy=0). A start while busy=1 is ignored. Writes to undefined bits are ignored.
//   Register map:
//     0 TXDATA W: push data[7:0]. R: 0.
//     1 STATUS R: [0]empty [1]full [2]active [3]overflow [15:8]count. W: data[3]=1 clears overflow.
//     2 DIVISOR R/W [15:0]. Values <4 are clamped to 4. Latched into the bit timer at frame start, so a write mid-frame is not seen until the next frame.
//     3 CTRL R/W [0]tx_en [1]irq_en.
//   FIFO push rule: accepted if count<FIFO_DEPTH, or if a pop happens in the same cycle.
//     Otherwise the byte is dropped and overflow (sticky) is set.
//     Simultaneous push+pop leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
//   FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//     IDLE: uart_tx=1. If tx_en & ~empty: pop the FIFO into the shift register, latch div, go to START.
//     START: uart_tx=0 for div cycles.
//     DATA: 8 bits, LSB first, each held for div cycles; bit counter 0..7.
//     STOP: uart_tx=1 for div cycles. Then, if tx_en & ~empty, go directly to START with the next byte (back-to-back, no idle gap); else go to IDLE.
//   Frame length is exactly 10*div cycles. active=1 whenever FSM != IDLE.
//   tx_en cleared mid-frame: the current frame completes and no further pop occurs. The FIFO contents are retained.
//   irq: 1-cycle pulse on the STOP->IDLE transition when the FIFO is empty and irq_en=1.
//   Reset mid-frame: uart_tx=1 from the next cycle, FIFO flushed, a pending access aborted (busy=0).
// TESTING
//   1 Reset, read STATUS -> q=0x00000001; read DIVISOR -> q=217. busy is high for exactly 2 cycles per access.
//   2 DIV=4, CTRL=1, write 0xA5 -> uart_tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total.
//   3 CTRL=0, push 17 bytes with FIFO_DEPTH=16 -> STATUS = full=1, overflow=1, count=16. Write STATUS data[3]=1 -> overflow=0.
//   4 DIV=4, CTRL=3, push 0x00 then 0xFF -> two frames with no idle gap, 80 cycles, single irq pulse after the second stop bit.
//   5 Write DIVISOR=8 during a frame with div=4 -> current frame stays at 4 cycles/bit, next frame uses 8. DIVISOR=1 -> 4 cycles/bit.
//   6 Assert reset in bit 3 of a frame -> uart_tx=1 next cycle, STATUS empty=1 count=0, busy=0.

Source files
------------

// File: rtl/bus_uart_tx.sv
// CPU-bus UART transmitter: register access over the start/busy handshake,
// a byte FIFO, and an 8N1 serialiser with a programmable bit divisor.
module bus_uart_tx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_DEFAULT = 217
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  address,
    input  logic [31:0] data,
    input  logic        we,
    input  logic        start,
    output logic        busy,
    output logic [31:0] q,
    output logic        uart_tx,
    output logic        irq
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic          busy_r;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [15:0]   div_reg;
    logic [1:0]    ctrl;
    logic          overflow;

    state_t        state;
    logic [15:0]   tick;
    logic [15:0]   div_lat;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;

    logic          accept;
    logic          wr_acc;
    logic          push_req;
    logic          push_ok;
    logic          drop;
    logic          pop;
    logic          empty;
    logic          full;
    logic          active;
    logic          tick_done;
    logic          load_next;
    logic [7:0]    fifo_head;
    logic [31:0]   status_word;
    logic [31:0]   rd_mux;
    logic          unused_data;

    assign unused_data = ^data[31:16];

    // Only a start seen while no access is in flight is accepted.
    assign accept   = start & sel & ~busy_r;
    assign busy     = accept | busy_r;
    assign wr_acc   = accept & we;
    assign push_req = wr_acc && (address == 2'd0);

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_C);
    assign active    = (state != S_IDLE);
    assign tick_done = (tick == div_lat - 16'd1);
    assign load_next = ctrl[0] & ~empty;
    assign fifo_head = mem[rd_ptr];

    // A byte is fetched when idle, or at the last stop-bit cycle for back-to-back frames.
    assign pop     = load_next && ((state == S_IDLE) || ((state == S_STOP) && tick_done));
    assign push_ok = push_req & (~full | pop);
    assign drop    = push_req & ~push_ok;

    assign status_word = ((32'(count) << 8) & 32'h0000_FF00)
                       | {28'h0, overflow, active, full, empty};

    always_comb begin
        rd_mux = 32'h0;
        case (address)
            2'd0: rd_mux = 32'h0;
            2'd1: rd_mux = status_word;
            2'd2: rd_mux = {16'h0, div_reg};
            2'd3: rd_mux = {30'h0, ctrl};
            default: rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r   <= 1'b0;
            q        <= 32'h0;
            div_reg  <= 16'(DIV_DEFAULT);
            ctrl     <= 2'b00;
            overflow <= 1'b0;
        end else begin
            busy_r <= accept;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (wr_acc) begin
                case (address)
                    2'd1: begin
                        if (data[3]) begin
                            overflow <= 1'b0;
                        end
                    end
                    2'd2: div_reg <= (data[15:0] < 16'd4) ? 16'd4 : data[15:0];
                    2'd3: ctrl    <= data[1:0];
                    default: ;
                endcase
            end
            if (accept && !we) begin
                q <= rd_mux;
            end
        end
    end

    // Serialiser: every state lasts div_lat cycles; uart_tx is updated on the edge leaving a bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            uart_tx   <= 1'b1;
            irq       <= 1'b0;
            tick      <= 16'd0;
            div_lat   <= 16'd4;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            irq <= 1'b0;
            case (state)
                S_IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shift_reg <= fifo_head;
                        div_lat   <= div_reg;
                        tick      <= 16'd0;
                        uart_tx   <= 1'b0;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    if (tick_done) begin
                        tick      <= 16'd0;
                        bit_cnt   <= 3'd0;
                        uart_tx   <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state     <= S_DATA;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                S_DATA: begin
                    if (tick_done) begin
                        tick <= 16'd0;
                        if (bit_cnt == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= S_STOP;
                        end else begin
                            bit_cnt   <= bit_cnt + 3'd1;
                            uart_tx   <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                S_STOP: begin
                    if (tick_done) begin
                        tick <= 16'd0;
                        if (pop) begin
                            shift_reg <= fifo_head;
                            div_lat   <= div_reg;
                            uart_tx   <= 1'b0;
                            state     <= S_START;
                        end else begin
                            irq   <= empty & ctrl[1];
                            state <= S_IDLE;
                        end
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed bench for bus_uart_tx: register access, frame shape and timing,
// FIFO overflow, back-to-back frames, divisor latching and mid-frame reset.
module tb_bus_uart_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [1:0]  address;
    logic [31:0] data;
    logic        we;
    logic        start;
    logic        busy;
    logic [31:0] q;
    logic        uart_tx;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;
    int irq_hits;

    logic [9:0] cap_bits;
    logic       cap_found;
    logic       cap_stable;

    bus_uart_tx #(.FIFO_DEPTH(16), .DIV_DEFAULT(217)) dut (
        .clk(clk), .reset(reset), .sel(sel), .address(address), .data(data),
        .we(we), .start(start), .busy(busy), .q(q), .uart_tx(uart_tx), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // All tasks start and end 1 ns after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        sel = 1'b0; start = 1'b0; we = 1'b0; address = 2'd0; data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic bus_access(input logic w, input logic [1:0] a, input logic [31:0] d,
                              output logic [31:0] rd, output int bcyc);
        bcyc = 0;
        sel = 1'b1; start = 1'b1; we = w; address = a; data = d;
        #1;
        if (busy === 1'b1) bcyc++;
        @(posedge clk); #1;
        sel = 1'b0; start = 1'b0; we = 1'b0; data = 32'h0;
        if (busy === 1'b1) bcyc++;
        @(posedge clk); #1;
        if (busy === 1'b1) bcyc++;
        rd = q;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int bc;
        bus_access(1'b1, a, d, rd, bc);
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] rd, output int bc);
        bus_access(1'b0, a, 32'h0, rd, bc);
    endtask

    // Waits up to budget cycles for the start bit, then samples 10*div cycles.
    task automatic capture_frame(input int div, input int budget);
        for (int w = 0; w < budget && uart_tx !== 1'b0; w++) begin
            @(posedge clk); #1;
        end
        cap_found  = (uart_tx === 1'b0);
        cap_stable = 1'b1;
        cap_bits   = '0;
        for (int i = 0; i < 10 * div; i++) begin
            if (i % div == 0) cap_bits[i / div] = uart_tx;
            else if (uart_tx !== cap_bits[i / div]) cap_stable = 1'b0;
            if (irq === 1'b1) irq_hits++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int bc;
        do_reset();
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (q !== 32'h0) $display("FAIL reset_q: got %h expected 0", q); else n_pass++;
        n_total++; if (uart_tx !== 1'b1) $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); else n_pass++;
        n_total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else n_pass++;
        read_reg(2'd1, rd, bc);
        n_total++; if (rd !== 32'h1) $display("FAIL reset_status: got %h expected 00000001", rd); else n_pass++;
        n_total++; if (bc !== 2) $display("FAIL busy_cycles_read: got %0d expected 2", bc); else n_pass++;
        read_reg(2'd2, rd, bc);
        n_total++; if (rd !== 32'd217) $display("FAIL reset_divisor: got %0d expected 217", rd); else n_pass++;
        n_total++; if (bc !== 2) $display("FAIL busy_cycles_read2: got %0d expected 2", bc); else n_pass++;
        read_reg(2'd3, rd, bc);
        n_total++; if (rd !== 32'h0) $display("FAIL reset_ctrl: got %h expected 0", rd); else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [31:0] rd;
        int bc;
        write_reg(2'd2, 32'd4);
        write_reg(2'd3, 32'd1);
        write_reg(2'd0, 32'hA5);
        capture_frame(4, 4);
        n_total++; if (cap_found !== 1'b1) $display("FAIL a5_start_seen: got %b expected 1", cap_found); else n_pass++;
        n_total++; if (cap_bits !== 10'b1101001010) $display("FAIL a5_bits: got %b expected 1101001010", cap_bits); else n_pass++;
        n_total++; if (cap_stable !== 1'b1) $display("FAIL a5_bit_width: got %b expected 1", cap_stable); else n_pass++;
        n_total++; if (uart_tx !== 1'b1) $display("FAIL a5_idle_after_40: got %b expected 1", uart_tx); else n_pass++;
        read_reg(2'd1, rd, bc);
        n_total++; if (rd !== 32'h1) $display("FAIL a5_status_idle: got %h expected 00000001", rd); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        int bc;
        do_reset();
        for (int i = 0; i < 17; i++) write_reg(2'd0, 32'(i));
        read_reg(2'd1, rd, bc);
        n_total++; if (rd !== 32'h0000100A) $display("FAIL ovf_status: got %h expected 0000100A", rd); else n_pass++;
        read_reg(2'd0, rd, bc);
        n_total++; if (rd !== 32'h0) $display("FAIL txdata_read: got %h expected 0", rd); else n_pass++;
        n_total++; if (uart_tx !== 1'b1) $display("FAIL ovf_no_tx: got %b expected 1", uart_tx); else n_pass++;
        write_reg(2'd1, 32'h8);
        read_reg(2'd1, rd, bc);
        n_total++; if (rd !== 32'h00001002) $display("FAIL ovf_cleared: got %h expected 00001002", rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        write_reg(2'd2, 32'd4);
        write_reg(2'd3, 32'd2);
        write_reg(2'd0, 32'h00);
        write_reg(2'd0, 32'hFF);
        irq_hits = 0;
        write_reg(2'd3, 32'd3);
        capture_frame(4, 4);
        n_total++; if (cap_found !== 1'b1) $display("FAIL b2b_first_start: got %b expected 1", cap_found); else n_pass++;
        n_total++; if (cap_bits !== 10'b1000000000) $display("FAIL b2b_first_bits: got %b expected 1000000000", cap_bits); else n_pass++;
        n_total++; if (cap_stable !== 1'b1) $display("FAIL b2b_first_width: got %b expected 1", cap_stable); else n_pass++;
        capture_frame(4, 0);
        n_total++; if (cap_found !== 1'b1) $display("FAIL b2b_no_gap: got %b expected 1", cap_found); else n_pass++;
        n_total++; if (cap_bits !== 10'b1111111110) $display("FAIL b2b_second_bits: got %b expected 1111111110", cap_bits); else n_pass++;
        n_total++; if (cap_stable !== 1'b1) $display("FAIL b2b_second_width: got %b expected 1", cap_stable); else n_pass++;
        n_total++; if (irq_hits !== 0) $display("FAIL b2b_irq_early: got %0d expected 0", irq_hits); else n_pass++;
        n_total++; if (irq !== 1'b1) $display("FAIL b2b_irq_pulse: got %b expected 1", irq); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (irq !== 1'b0) $display("FAIL b2b_irq_width: got %b expected 0", irq); else n_pass++;
        n_total++; if (uart_tx !== 1'b1) $display("FAIL b2b_idle: got %b expected 1", uart_tx); else n_pass++;
    endtask

    task automatic test_divisor_latch();
        write_reg(2'd3, 32'd0);
        write_reg(2'd2, 32'd4);
        write_reg(2'd0, 32'h3C);
        write_reg(2'd0, 32'hC3);
        write_reg(2'd3, 32'd1);
        fork
            capture_frame(4, 0);
            begin
                repeat (3) @(posedge clk);
                #1;
                write_reg(2'd2, 32'd8);
            end
        join
        n_total++; if (cap_bits !== 10'b1001111000) $display("FAIL div_old_bits: got %b expected 1001111000", cap_bits); else n_pass++;
        n_total++; if (cap_stable !== 1'b1) $display("FAIL div_old_width: got %b expected 1", cap_stable); else n_pass++;
        capture_frame(8, 0);
        n_total++; if (cap_found !== 1'b1) $display("FAIL div_new_start: got %b expected 1", cap_found); else n_pass++;
        n_total++; if (cap_bits !== 10'b1110000110) $display("FAIL div_new_bits: got %b expected 1110000110", cap_bits); else n_pass++;
        n_total++; if (cap_stable !== 1'b1) $display("FAIL div_new_width: got %b expected 1", cap_stable); else n_pass++;
        write_reg(2'd2, 32'd1);
        write_reg(2'd0, 32'h5A);
        capture_frame(4, 0);
        n_total++; if (cap_bits !== 10'b1010110100) $display("FAIL div_clamp_bits: got %b expected 1010110100", cap_bits); else n_pass++;
        n_total++; if (cap_stable !== 1'b1) $display("FAIL div_clamp_width: got %b expected 1", cap_stable); else n_pass++;
        n_total++; if (uart_tx !== 1'b1) $display("FAIL div_clamp_end: got %b expected 1", uart_tx); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        int bc;
        do_reset();
        write_reg(2'd2, 32'd4);
        write_reg(2'd0, 32'h00);
        write_reg(2'd0, 32'h11);
        write_reg(2'd3, 32'd1);
        repeat (17) begin
            @(posedge clk); #1;
        end
        n_total++; if (uart_tx !== 1'b0) $display("FAIL mid_bit3_low: got %b expected 0", uart_tx); else n_pass++;
        sel = 1'b1; start = 1'b1; we = 1'b0; address = 2'd1;
        @(posedge clk); #1;
        sel = 1'b0; start = 1'b0;
        reset = 1'b1;
        n_total++; if (busy !== 1'b1) $display("FAIL mid_access_pending: got %b expected 1", busy); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        n_total++; if (uart_tx !== 1'b1) $display("FAIL mid_uart_high: got %b expected 1", uart_tx); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL mid_busy_abort: got %b expected 0", busy); else n_pass++;
        n_total++; if (q !== 32'h0) $display("FAIL mid_q_cleared: got %h expected 0", q); else n_pass++;
        read_reg(2'd1, rd, bc);
        n_total++; if (rd !== 32'h1) $display("FAIL mid_status_flushed: got %h expected 00000001", rd); else n_pass++;
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_total++; if (uart_tx !== 1'b1) $display("FAIL mid_stays_idle: got %b expected 1", uart_tx); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_back_to_back();
        test_divisor_latch();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
